// File: rtl/sched_pkg.sv
// Shared definitions for the sensor scheduler and its neighbours:
// FSM state encoding, in-flight sensor encodings and a saturating increment.
package sched_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN_SR04 = 2'd1,
      RUN_DHT  = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [1:0] ACT_NONE = 2'b00;
   localparam logic [1:0] ACT_SR04 = 2'b01;
   localparam logic [1:0] ACT_DHT  = 2'b10;

   // 8-bit increment that sticks at 255 instead of wrapping
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      if (value == 8'hFF) begin
         return 8'hFF;
      end else begin
         return value + 8'd1;
      end
   endfunction

endpackage

// File: rtl/sensor_scheduler_if.sv
// Control/sensor-side bundle of the sensor scheduler.
// master: top control unit plus sensor tops (requests, done pulses, auto enable).
// slave : the scheduler itself (start pulses, status, error and statistics).
interface sensor_scheduler_if;
   logic       auto_en;
   logic       req_sr04;
   logic       req_dht;
   logic       sr04_done;
   logic       dht_done;
   logic       sr04_start;
   logic       dht_start;
   logic       busy;
   logic [1:0] active;
   logic       timeout_err;
   logic       err_src;
   logic [7:0] sr04_cnt;
   logic [7:0] dht_cnt;

   modport master (
      output auto_en, req_sr04, req_dht, sr04_done, dht_done,
      input  sr04_start, dht_start, busy, active, timeout_err, err_src,
             sr04_cnt, dht_cnt
   );

   modport slave (
      input  auto_en, req_sr04, req_dht, sr04_done, dht_done,
      output sr04_start, dht_start, busy, active, timeout_err, err_src,
             sr04_cnt, dht_cnt
   );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one registered 1-cycle pulse every CLKS_PER_MS
// clocks. Shared by all ms-based timing blocks.
module ms_tick_gen #(
   parameter int CLKS_PER_MS = 100_000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

   logic [CW-1:0] cnt;

   // free-running divider; tick registered so consumers see a clean pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         if (cnt == LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
         tick <= (cnt == LAST);
      end
   end
endmodule

// File: rtl/sensor_scheduler.sv
// Sensor scheduler: merges button/UART requests and periodic auto-triggers for
// the SR04 ranger and DHT11 sensor into one non-overlapping schedule, enforces
// the DHT11 re-trigger guard and per-sensor completion timeouts.
// Optional macro SCHED_STATS_EN enables saturating completed-run counters;
// without it sr04_cnt/dht_cnt are tied to zero.
module sensor_scheduler
   import sched_pkg::*;
#(
   parameter int CLKS_PER_MS     = 100_000,
   parameter int SR04_PERIOD_MS  = 200,
   parameter int DHT_PERIOD_MS   = 2000,
   parameter int DHT_MIN_MS      = 1000,
   parameter int SR04_TIMEOUT_MS = 40,
   parameter int DHT_TIMEOUT_MS  = 30
) (
   input  logic               clk,
   input  logic               rst,
   sensor_scheduler_if.slave  bus
);
   localparam int SPW    = $clog2(SR04_PERIOD_MS + 1);
   localparam int DPW    = $clog2(DHT_PERIOD_MS + 1);
   localparam int GW     = $clog2(DHT_MIN_MS + 1);
   localparam int TO_MAX = (SR04_TIMEOUT_MS > DHT_TIMEOUT_MS) ? SR04_TIMEOUT_MS : DHT_TIMEOUT_MS;
   localparam int TW     = $clog2(TO_MAX + 1);

   state_t          state, next_state;
   logic            ms_tick;
   logic            sr04_pend, dht_pend;
   logic [SPW-1:0]  sr04_per;
   logic [DPW-1:0]  dht_per;
   logic [GW-1:0]   dht_guard;
   logic [TW-1:0]   to_cnt;
   logic            last_dht, served_dht;
   logic            sr04_expire, dht_expire;
   logic            sr04_elig, dht_elig;
   logic            sr04_grant, dht_grant;
   logic            run_done, run_timeout;
   logic            busy, timeout_err, err_src;
   logic [1:0]      active;

   ms_tick_gen #(.CLKS_PER_MS(CLKS_PER_MS)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (ms_tick)
   );

   assign sr04_expire = bus.auto_en && ms_tick && (sr04_per == SPW'(SR04_PERIOD_MS - 1));
   assign dht_expire  = bus.auto_en && ms_tick && (dht_per == DPW'(DHT_PERIOD_MS - 1));
   assign sr04_elig   = sr04_pend;
   assign dht_elig    = dht_pend && (dht_guard == GW'(DHT_MIN_MS));

   // next-state, grant arbitration and run termination
   always_comb begin
      next_state  = state;
      sr04_grant  = 1'b0;
      dht_grant   = 1'b0;
      run_done    = 1'b0;
      run_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (sr04_elig && dht_elig) begin
               // both ready: serve the one that did not run last
               if (last_dht) begin
                  sr04_grant = 1'b1;
               end else begin
                  dht_grant = 1'b1;
               end
            end else if (sr04_elig) begin
               sr04_grant = 1'b1;
            end else if (dht_elig) begin
               dht_grant = 1'b1;
            end else begin
               sr04_grant = 1'b0;
            end
            if (sr04_grant) begin
               next_state = RUN_SR04;
            end else if (dht_grant) begin
               next_state = RUN_DHT;
            end else begin
               next_state = IDLE;
            end
         end
         RUN_SR04: begin
            // done wins over a coincident timeout
            if (bus.sr04_done) begin
               run_done   = 1'b1;
               next_state = DONE;
            end else if (to_cnt >= TW'(SR04_TIMEOUT_MS)) begin
               run_timeout = 1'b1;
               next_state  = DONE;
            end else begin
               next_state = RUN_SR04;
            end
         end
         RUN_DHT: begin
            if (bus.dht_done) begin
               run_done   = 1'b1;
               next_state = DONE;
            end else if (to_cnt >= TW'(DHT_TIMEOUT_MS)) begin
               run_timeout = 1'b1;
               next_state  = DONE;
            end else begin
               next_state = RUN_DHT;
            end
         end
         DONE: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // registered status: busy/active follow the run states, error pulse on timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy        <= 1'b0;
         active      <= ACT_NONE;
         timeout_err <= 1'b0;
         err_src     <= 1'b0;
      end else begin
         busy <= (next_state == RUN_SR04) || (next_state == RUN_DHT);
         case (next_state)
            RUN_SR04: active <= ACT_SR04;
            RUN_DHT:  active <= ACT_DHT;
            default:  active <= ACT_NONE;
         endcase
         timeout_err <= run_timeout;
         if (run_timeout) begin
            err_src <= (state == RUN_DHT);
         end
      end
   end

   // pending flags: requests and expiries merge; a new set wins over the clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr04_pend <= 1'b0;
         dht_pend  <= 1'b0;
      end else begin
         sr04_pend <= bus.req_sr04 || sr04_expire || (sr04_pend && !sr04_grant);
         dht_pend  <= bus.req_dht || dht_expire || (dht_pend && !dht_grant);
      end
   end

   // auto-trigger period counters, held at zero while auto mode is off
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr04_per <= '0;
         dht_per  <= '0;
      end else if (!bus.auto_en) begin
         sr04_per <= '0;
         dht_per  <= '0;
      end else if (ms_tick) begin
         sr04_per <= sr04_expire ? '0 : sr04_per + SPW'(1);
         dht_per  <= dht_expire ? '0 : dht_per + DPW'(1);
      end
   end

   // DHT re-trigger guard: restarts on each DHT start, saturates at the minimum spacing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dht_guard <= GW'(DHT_MIN_MS);
      end else if (dht_grant) begin
         dht_guard <= '0;
      end else if (ms_tick && (dht_guard != GW'(DHT_MIN_MS))) begin
         dht_guard <= dht_guard + GW'(1);
      end
   end

   // run timeout counter: zero outside the run states, counts ms while running
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if ((state != RUN_SR04) && (state != RUN_DHT)) begin
         to_cnt <= '0;
      end else if (ms_tick && (to_cnt != TW'(TO_MAX))) begin
         to_cnt <= to_cnt + TW'(1);
      end
   end

   // round-robin memory: remember who was granted, commit it in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_dht   <= 1'b1;
         served_dht <= 1'b0;
      end else begin
         if (sr04_grant) begin
            served_dht <= 1'b0;
         end else if (dht_grant) begin
            served_dht <= 1'b1;
         end
         if (state == DONE) begin
            last_dht <= served_dht;
         end
      end
   end

`ifdef SCHED_STATS_EN
   logic       run_ok;
   logic [7:0] sr04_cnt, dht_cnt;

   // completed-run statistics, counted in DONE only for runs that saw their done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         run_ok   <= 1'b0;
         sr04_cnt <= 8'd0;
         dht_cnt  <= 8'd0;
      end else begin
         if (run_done || run_timeout) begin
            run_ok <= run_done;
         end
         if ((state == DONE) && run_ok) begin
            if (served_dht) begin
               dht_cnt <= sat_inc8(dht_cnt);
            end else begin
               sr04_cnt <= sat_inc8(sr04_cnt);
            end
         end
      end
   end

   assign bus.sr04_cnt = sr04_cnt;
   assign bus.dht_cnt  = dht_cnt;
`else
   assign bus.sr04_cnt = 8'd0;
   assign bus.dht_cnt  = 8'd0;
`endif

   assign bus.sr04_start  = sr04_grant;
   assign bus.dht_start   = dht_grant;
   assign bus.busy        = busy;
   assign bus.active      = active;
   assign bus.timeout_err = timeout_err;
   assign bus.err_src     = err_src;

endmodule

// File: tb/tb_sensor_scheduler.sv
// Self-checking bench for sensor_scheduler with scaled timing
// (10 clocks per ms). Start pulses are matched against a scoreboard of
// expected {sensor, cycle window} entries pushed when stimulus is driven.
module tb_sensor_scheduler;
   import sched_pkg::*;

`ifdef SCHED_STATS_EN
   localparam logic [7:0] ONE_RUN = 8'd1;
`else
   localparam logic [7:0] ONE_RUN = 8'd0;
`endif

   typedef struct {
      bit is_dht;
      int lo;
      int hi;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   sb_on = 1'b1;
   exp_t sb[$];
   exp_t mon_e;
   int   dht_s;

   sensor_scheduler_if bus();

   sensor_scheduler #(
      .CLKS_PER_MS(10), .SR04_PERIOD_MS(5), .DHT_PERIOD_MS(20),
      .DHT_MIN_MS(8), .SR04_TIMEOUT_MS(4), .DHT_TIMEOUT_MS(3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // start-pulse monitor: overlap check and scoreboard matching
   always @(negedge clk) begin
      if (bus.sr04_start || bus.dht_start) begin
         checks++;
         if ((bus.sr04_start && bus.dht_start) || bus.busy) begin
            failures++;
            $display("FAIL start_overlap: cycle %0d sr04_start=%0b dht_start=%0b busy=%0b, required single start while idle",
                     cyc, bus.sr04_start, bus.dht_start, bus.busy);
         end
         if (sb_on) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_start: dht=%0b at cycle %0d, required no start", bus.dht_start, cyc);
            end else begin
               mon_e = sb.pop_front();
               if ((mon_e.is_dht !== bus.dht_start) || (cyc < mon_e.lo) || (cyc > mon_e.hi)) begin
                  failures++;
                  $display("FAIL start_match: got dht=%0b at cycle %0d, required dht=%0b in [%0d,%0d]",
                           bus.dht_start, cyc, mon_e.is_dht, mon_e.lo, mon_e.hi);
               end
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic void expect_start(input bit is_dht, input int lo, input int hi);
      exp_t e;
      e.is_dht = is_dht;
      e.lo = lo;
      e.hi = hi;
      sb.push_back(e);
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.auto_en = 1'b0; bus.req_sr04 = 1'b0; bus.req_dht = 1'b0;
      bus.sr04_done = 1'b0; bus.dht_done = 1'b0;
      step(3);
      rst = 1'b0;
      step(2);
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b1;
      step(2);
      checks++;
      if ({bus.busy, bus.active, bus.timeout_err, bus.err_src, bus.sr04_start, bus.dht_start} !== 7'd0) begin
         failures++;
         $display("FAIL reset_outputs: got busy=%0b active=%0b terr=%0b src=%0b starts=%0b%0b, required all 0",
                  bus.busy, bus.active, bus.timeout_err, bus.err_src, bus.sr04_start, bus.dht_start);
      end
      checks++;
      if ({bus.sr04_cnt, bus.dht_cnt} !== 16'd0) begin
         failures++;
         $display("FAIL reset_counts: got %0d/%0d, required 0/0", bus.sr04_cnt, bus.dht_cnt);
      end
      rst = 1'b0;
      step(5);
      checks++;
      if (bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy=%0b, required 0", bus.busy);
      end
   endtask

   task automatic test_single_sr04();
      int c;
      c = cyc;
      bus.req_sr04 = 1'b1;
      expect_start(1'b0, c + 1, c + 1);
      step(1);
      bus.req_sr04 = 1'b0;
      checks++;
      if (bus.sr04_start !== 1'b1) begin
         failures++;
         $display("FAIL sr04_start_issue: got %0b, required 1", bus.sr04_start);
      end
      step(1);
      checks++;
      if ((bus.busy !== 1'b1) || (bus.active !== ACT_SR04)) begin
         failures++;
         $display("FAIL sr04_busy: got busy=%0b active=%0b, required 1/01", bus.busy, bus.active);
      end
      step(12);
      bus.sr04_done = 1'b1;
      step(1);
      bus.sr04_done = 1'b0;
      checks++;
      if ((bus.busy !== 1'b0) || (bus.active !== ACT_NONE)) begin
         failures++;
         $display("FAIL sr04_done_state: got busy=%0b active=%0b, required 0/00", bus.busy, bus.active);
      end
      step(1);
      checks++;
      if (bus.sr04_cnt !== ONE_RUN) begin
         failures++;
         $display("FAIL sr04_cnt: got %0d, required %0d", bus.sr04_cnt, ONE_RUN);
      end
   endtask

   task automatic test_both_pending();
      int c, d;
      do_reset();
      c = cyc;
      bus.req_sr04 = 1'b1;
      bus.req_dht = 1'b1;
      expect_start(1'b0, c + 1, c + 1);
      step(1);
      bus.req_sr04 = 1'b0;
      bus.req_dht = 1'b0;
      checks++;
      if ((bus.sr04_start !== 1'b1) || (bus.dht_start !== 1'b0)) begin
         failures++;
         $display("FAIL both_first_grant: got sr04=%0b dht=%0b, required sr04 first", bus.sr04_start, bus.dht_start);
      end
      step(6);
      d = cyc;
      bus.sr04_done = 1'b1;
      expect_start(1'b1, d + 2, d + 2);
      step(1);
      bus.sr04_done = 1'b0;
      step(1);
      dht_s = cyc;
      checks++;
      if ((bus.dht_start !== 1'b1) || (bus.busy !== 1'b0)) begin
         failures++;
         $display("FAIL both_second_grant: got dht_start=%0b busy=%0b, required 1/0", bus.dht_start, bus.busy);
      end
      step(1);
      checks++;
      if (bus.active !== ACT_DHT) begin
         failures++;
         $display("FAIL dht_active: got %0b, required 10", bus.active);
      end
      step(4);
      bus.dht_done = 1'b1;
      step(1);
      bus.dht_done = 1'b0;
      step(2);
      checks++;
      if (bus.dht_cnt !== ONE_RUN) begin
         failures++;
         $display("FAIL dht_cnt: got %0d, required %0d", bus.dht_cnt, ONE_RUN);
      end
   endtask

   task automatic test_dht_guard();
      bit seen;
      step(dht_s + 25 - cyc);
      bus.req_dht = 1'b1;
      expect_start(1'b1, dht_s + 72, dht_s + 81);
      step(1);
      bus.req_dht = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (bus.dht_start) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL guard_start: no dht_start within bound, required one");
      end
      step(3);
      bus.dht_done = 1'b1;
      step(1);
      bus.dht_done = 1'b0;
      step(60);
   endtask

   task automatic test_timeout();
      int s, t;
      bit seen;
      do_reset();
      s = cyc + 1;
      bus.req_dht = 1'b1;
      expect_start(1'b1, s, s);
      step(1);
      bus.req_dht = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (bus.timeout_err) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      t = cyc;
      checks++;
      if (!seen || (t < s + 23) || (t > s + 32)) begin
         failures++;
         $display("FAIL dht_timeout_time: seen=%0b at cycle %0d, required in [%0d,%0d]", seen, t, s + 23, s + 32);
      end
      checks++;
      if ((bus.err_src !== 1'b1) || (bus.busy !== 1'b0) || (bus.dht_cnt !== 8'd0)) begin
         failures++;
         $display("FAIL dht_timeout_state: got src=%0b busy=%0b cnt=%0d, required 1/0/0", bus.err_src, bus.busy, bus.dht_cnt);
      end
      step(1);
      checks++;
      if (bus.timeout_err !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse: got %0b one cycle later, required 0", bus.timeout_err);
      end
      s = cyc + 1;
      bus.req_sr04 = 1'b1;
      expect_start(1'b0, s, s);
      step(1);
      bus.req_sr04 = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 70; i++) begin
         if (bus.timeout_err) begin
            seen = 1'b1;
            break;
         end
         step(1);
      end
      t = cyc;
      checks++;
      if (!seen || (t < s + 33) || (t > s + 42) || (bus.err_src !== 1'b0)) begin
         failures++;
         $display("FAIL sr04_timeout: seen=%0b cycle %0d src=%0b, required in [%0d,%0d] src 0", seen, t, bus.err_src, s + 33, s + 42);
      end
      step(2);
      checks++;
      if (bus.sr04_cnt !== 8'd0) begin
         failures++;
         $display("FAIL sr04_cnt_after_timeout: got %0d, required 0", bus.sr04_cnt);
      end
   endtask

   task automatic test_auto();
      int n_sr, n_dh, last_sr, last_dh, sr_cd, dh_cd, late;
      do_reset();
      sb_on = 1'b0;
      bus.auto_en = 1'b1;
      n_sr = 0; n_dh = 0; last_sr = -1; last_dh = -1; sr_cd = 0; dh_cd = 0;
      for (int i = 0; i < 920; i++) begin
         step(1);
         if (sr_cd > 0) begin
            sr_cd--;
            bus.sr04_done = (sr_cd == 0);
         end else begin
            bus.sr04_done = 1'b0;
         end
         if (dh_cd > 0) begin
            dh_cd--;
            bus.dht_done = (dh_cd == 0);
         end else begin
            bus.dht_done = 1'b0;
         end
         if (bus.sr04_start) begin
            if (last_sr >= 0) begin
               checks++;
               if ((cyc - last_sr < 45) || (cyc - last_sr > 55)) begin
                  failures++;
                  $display("FAIL auto_sr04_period: interval %0d, required 45..55", cyc - last_sr);
               end
            end
            last_sr = cyc; n_sr++; sr_cd = 3;
         end
         if (bus.dht_start) begin
            if (last_dh >= 0) begin
               checks++;
               if (cyc - last_dh != 200) begin
                  failures++;
                  $display("FAIL auto_dht_period: interval %0d, required 200", cyc - last_dh);
               end
            end
            last_dh = cyc; n_dh++; dh_cd = 3;
         end
      end
      checks++;
      if ((n_sr != 18) || (n_dh != 4)) begin
         failures++;
         $display("FAIL auto_counts: got sr04=%0d dht=%0d, required 18/4", n_sr, n_dh);
      end
      bus.auto_en = 1'b0;
      bus.sr04_done = 1'b0;
      bus.dht_done = 1'b0;
      late = 0;
      for (int i = 0; i < 300; i++) begin
         step(1);
         if (bus.sr04_start || bus.dht_start) late++;
      end
      checks++;
      if (late != 0) begin
         failures++;
         $display("FAIL auto_off: got %0d starts after auto_en=0, required 0", late);
      end
      sb_on = 1'b1;
   endtask

   task automatic test_rst_mid_run();
      int c, errs;
      do_reset();
      c = cyc;
      bus.req_dht = 1'b1;
      expect_start(1'b1, c + 1, c + 1);
      step(1);
      bus.req_dht = 1'b0;
      step(10);
      checks++;
      if ((bus.busy !== 1'b1) || (bus.active !== ACT_DHT)) begin
         failures++;
         $display("FAIL mid_run_state: got busy=%0b active=%0b, required 1/10", bus.busy, bus.active);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ((bus.busy !== 1'b0) || (bus.active !== ACT_NONE) || (bus.timeout_err !== 1'b0)) begin
         failures++;
         $display("FAIL async_reset: got busy=%0b active=%0b terr=%0b, required 0/00/0", bus.busy, bus.active, bus.timeout_err);
      end
      step(2);
      rst = 1'b0;
      errs = 0;
      for (int i = 0; i < 50; i++) begin
         step(1);
         if (bus.timeout_err !== 1'b0) errs++;
      end
      checks++;
      if (errs != 0) begin
         failures++;
         $display("FAIL abandoned_run_err: got %0d timeout pulses, required 0", errs);
      end
      c = cyc;
      bus.req_dht = 1'b1;
      expect_start(1'b1, c + 1, c + 1);
      step(1);
      bus.req_dht = 1'b0;
      checks++;
      if (bus.dht_start !== 1'b1) begin
         failures++;
         $display("FAIL dht_after_reset: got %0b, required 1", bus.dht_start);
      end
      step(3);
      bus.dht_done = 1'b1;
      step(1);
      bus.dht_done = 1'b0;
      step(3);
   endtask

   initial begin
      bus.auto_en = 1'b0; bus.req_sr04 = 1'b0; bus.req_dht = 1'b0;
      bus.sr04_done = 1'b0; bus.dht_done = 1'b0;
      test_reset();
      test_single_sr04();
      test_both_pending();
      test_dht_guard();
      test_timeout();
      test_auto();
      test_rst_mid_run();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d expected starts never seen, required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sensor_scheduler.md
Name: sensor_scheduler

Overview:
- Sequences the shared sensor measurement resources: the SR04 ultrasonic ranger and the DHT11 temperature/humidity sensor.
- Merges three request sources into a single non-overlapping schedule:
  - button/UART start pulses from the top control unit;
  - a periodic auto-trigger for each sensor.
- Enforces the DHT11 minimum re-trigger interval and per-sensor completion timeouts.
- Sits between the top control unit and the two sensor tops; drives their start inputs and consumes their done pulses.

Parameters:
- CLKS_PER_MS, 100_000: clock cycles per 1 ms tick (100 MHz clock).
- SR04_PERIOD_MS, 200: auto-trigger period for SR04.
- DHT_PERIOD_MS, 2000: auto-trigger period for DHT11.
- DHT_MIN_MS, 1000: minimum spacing between two DHT11 starts.
- SR04_TIMEOUT_MS, 40: maximum wait for sr04_done.
- DHT_TIMEOUT_MS, 30: maximum wait for dht_done.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- auto_en  in  1  enables the periodic auto-triggers.
- req_sr04  in  1  1-cycle SR04 measurement request.
- req_dht  in  1  1-cycle DHT11 measurement request.
- sr04_done  in  1  SR04 completion pulse.
- dht_done  in  1  DHT11 completion pulse.
- sr04_start  out  1  1-cycle start pulse to SR04.
- dht_start  out  1  1-cycle start pulse to DHT11.
- busy  out  1  high while a measurement is in flight.
- active  out  2  in-flight sensor: 01 = SR04, 10 = DHT11, 00 = none.
- timeout_err  out  1  1-cycle pulse when a run times out.
- err_src  out  1  sensor of the last timeout: 0 = SR04, 1 = DHT11 (held).
- sr04_cnt  out  8  completed SR04 runs (see Optional Feature).
- dht_cnt  out  8  completed DHT11 runs (see Optional Feature).

Behaviour:
- Reset values:
  - all outputs 0; FSM in IDLE; pending flags 0; period counters 0;
  - round-robin pointer favours SR04;
  - DHT guard counter preset to DHT_MIN_MS (satisfied), so the first DHT start is allowed immediately.
- Tick: a free-running counter produces ms_tick (1 cycle every CLKS_PER_MS cycles). All ms counters advance only on ms_tick.
- Pending flags:
  - sr04_pend is set by req_sr04 or by SR04 period expiry; dht_pend likewise.
  - A repeat request while already pending is merged (no queue depth).
  - A pending flag clears in the cycle its start pulse is issued.
  - A request for the sensor currently running sets pending, so it reruns afterwards.
- Auto period counters:
  - count only while auto_en = 1.
  - At PERIOD_MS - 1 on a tick they set the pending flag and wrap to 0.
  - auto_en = 0 clears the counters to 0 but does not clear pending flags.
- DHT guard:
  - reset to 0 on each dht_start, then counts ms ticks and saturates at DHT_MIN_MS.
  - dht_pend is eligible only when guard = DHT_MIN_MS.
- FSM states: IDLE, RUN_SR04, RUN_DHT, DONE.
  - IDLE:
    - if both sensors are eligible, grant the one opposite the pointer's last service;
    - if only one is eligible, grant it;
    - on grant, issue its start pulse in the same cycle as the transition to RUN_x; busy and active are set the next cycle.
  - RUN_x:
    - the ms timeout counter is cleared on entry;
    - x_done is sampled from the cycle after the start pulse;
    - on done, go to DONE;
    - when the counter reaches TIMEOUT_MS, pulse timeout_err, set err_src, go to DONE;
    - done of the other sensor is ignored;
    - done and timeout in the same cycle counts as done.
  - DONE: exactly 1 cycle; busy = 0, active = 00; the pointer records the served sensor; return to IDLE.
  - This guarantees at least one idle cycle between runs, so starts never overlap.
- rst asserted mid-run: immediate return to IDLE; the in-flight run is abandoned and no error is reported.

Optional Feature:
- Macro SCHED_STATS_EN.
- When defined: sr04_cnt and dht_cnt are 8-bit saturating counters (stop at 255), incremented in DONE for runs that completed (not timed out); both reset to 0.
- When undefined: both ports are present and tied to 0, so the port list is unchanged.

Decomposition:
- Shared package sched_pkg holds:
  - state encoding constants (IDLE = 0, RUN_SR04 = 1, RUN_DHT = 2, DONE = 3);
  - active encodings (ACT_NONE, ACT_SR04, ACT_DHT).
- Sub-module ms_tick_gen (parameter CLKS_PER_MS, inputs clk/rst, output 1-cycle tick) is shared with other ms-based blocks.

Test Plan:
All scenarios use CLKS_PER_MS = 10 and scaled parameters (SR04_PERIOD_MS = 5, DHT_PERIOD_MS = 20, DHT_MIN_MS = 8, SR04_TIMEOUT_MS = 4, DHT_TIMEOUT_MS = 3).
1. Reset then req_sr04 at cycle 5 -> sr04_start pulses at cycle 6; busy = 1, active = 01 from cycle 7. sr04_done at cycle 20 -> busy = 0 at cycle 21; sr04_cnt = 1 (macro on).
2. req_sr04 and req_dht in the same cycle while idle -> SR04 runs first (pointer reset state). dht_start pulses exactly 2 cycles after sr04_done (DONE, then IDLE). The two starts never overlap.
3. dht completes; req_dht issued 2 ms later -> no dht_start until guard reaches 8 ms after the previous dht_start; then exactly one pulse.
4. req_dht with dht_done never asserted -> timeout_err pulse about 30 cycles after start, err_src = 1, dht_cnt unchanged; FSM is back in IDLE 1 cycle later.
5. auto_en = 1 with no done stalls (done returned 3 cycles after each start) -> sr04_start every 50 cycles; DHT start every 200 cycles, interleaved without overlap. Deassert auto_en -> no further starts.
6. rst asserted while in RUN_DHT -> busy = 0, active = 00, and no timeout_err. After release, req_dht starts immediately (guard preset).
